// File: rtl/mcf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcf_pkg: shared defaults and types for the multi-channel FIFO.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mcf_pkg;

  localparam int unsigned MCF_NUM_CH = 4;
  localparam int unsigned MCF_BURST  = 2;
  localparam int unsigned MCF_CH_W   = $clog2(MCF_NUM_CH);

  typedef logic [MCF_CH_W-1:0] ch_id_t;

endpackage
`default_nettype wire

// File: rtl/mcf_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcf_rr_pick: first set request at or after start_i, wrapping modulo N.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mcf_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] c_N = (IDX_W+1)'(N);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  always_comb begin
    // Rotate so that start_i lands on bit 0; doubling the vector makes the
    // wrap work for non-power-of-two N as long as start_i < N.
    w_rot   = N'({req_i, req_i} >> start_i);
    found_o = |w_rot;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
      end
    end
    w_sum = {1'b0, start_i} + {1'b0, w_off};
    if (w_sum >= c_N) begin
      w_sum = w_sum - c_N;
    end
    idx_o = w_sum[IDX_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mcf_pop_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcf_pop_scheduler: burst-limited round-robin pop of NUM_CH FIFOs.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mcf_pop_scheduler
  import mcf_pkg::*;
#(
  parameter int unsigned NUM_CH     = MCF_NUM_CH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST      = MCF_BURST,
  parameter int unsigned CH_W       = $clog2(NUM_CH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [NUM_CH-1:0]                    ch_empty_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_data_i,
  output logic [NUM_CH-1:0]                    ch_pop_o,
  output logic                                 out_valid_o,
  output logic [DATA_WIDTH-1:0]                out_data_o,
  output logic [CH_W-1:0]                      out_ch_o,
  input  logic                                 out_ready_i
);

  localparam int unsigned     BW          = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0]   c_BURST_MAX = BW'(BURST - 1);
  localparam logic [CH_W-1:0] c_LAST_CH   = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]       cur_q,   cur_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  own_q,   own_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [CH_W-1:0]       ch_q,    ch_d;

  logic            w_load;
  logic            w_active;
  logic            w_can_stay;
  logic [CH_W-1:0] w_start;
  logic            w_found;
  logic [CH_W-1:0] w_scan_idx;
  logic            w_grant;
  logic [CH_W-1:0] w_gidx;

  assign w_load   = ~valid_q | out_ready_i;
  assign w_active = w_load & ~flush_i;

  // own_q marks that cur_q was really granted; after reset or flush cur_q only
  // seeds the scan origin, so the first grant goes to the lowest ready channel.
  assign w_can_stay = own_q & ~ch_empty_i[cur_q] & (burst_q != c_BURST_MAX);
  assign w_start    = (cur_q == c_LAST_CH) ? '0 : cur_q + 1'b1;

  mcf_rr_pick #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_pick (
    .req_i   (~ch_empty_i),
    .start_i (w_start),
    .found_o (w_found),
    .idx_o   (w_scan_idx)
  );

  assign w_grant = w_active & (w_can_stay | w_found);
  assign w_gidx  = w_can_stay ? cur_q : w_scan_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pop
    assign ch_pop_o[i] = ~rst & w_grant & (w_gidx == CH_W'(i));
  end

  always_comb begin
    cur_d   = cur_q;
    burst_d = burst_q;
    own_d   = own_q;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (flush_i) begin
      valid_d = 1'b0;
      cur_d   = c_LAST_CH;
      burst_d = '0;
      own_d   = 1'b0;
    end else if (w_load) begin
      if (w_grant) begin
        valid_d = 1'b1;
        data_d  = ch_data_i[w_gidx];
        ch_d    = w_gidx;
        cur_d   = w_gidx;
        own_d   = 1'b1;
        // A scan that wraps back to the owner keeps the count saturated.
        if (w_can_stay) begin
          burst_d = burst_q + 1'b1;
        end else if (own_q && (w_gidx == cur_q)) begin
          burst_d = burst_q;
        end else begin
          burst_d = '0;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= c_LAST_CH;
      burst_q <= '0;
      own_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      cur_q   <= cur_d;
      burst_q <= burst_d;
      own_q   <= own_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;

endmodule
`default_nettype wire
